// File: rtl/bridge_pkg.sv
// Shared types for the AHB-to-APB bridge: AHB transfer/size/response codes
// and the slave front-end state encoding (also used by the bench).
// Optional error responses are enabled with the AHB_ERR_RESP_EN macro.
package bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // ERR1/ERR2 are only reachable when AHB_ERR_RESP_EN is defined.
    typedef enum logic [2:0] {
        FE_IDLE  = 3'd0,
        FE_WDATA = 3'd1,
        FE_REQ   = 3'd2,
        FE_WAIT  = 3'd3,
        FE_DONE  = 3'd4,
        FE_ERR1  = 3'd5,
        FE_ERR2  = 3'd6
    } fe_state_t;

endpackage

// File: rtl/ahb_addr_capture.sv
// Address-phase register: holds addr/write/size of the accepted AHB transfer
// for the duration of its data phase.
module ahb_addr_capture #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              preset_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              write_i,
    input  logic [2:0]        size_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              write_o,
    output logic [2:0]        size_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    // Load a new address phase only when the front end accepts a transfer.
    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (load_i) begin
            addr_d  = addr_i;
            write_d = write_i;
            size_d  = size_i;
        end
    end

    // Address-phase registers, cleared by the asynchronous bridge reset.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign size_o  = size_q;

endmodule

// File: rtl/ahb_slave_frontend.sv
// AHB-Lite slave front end of the AHB-to-APB bridge. Captures one AHB
// transfer, presents it on a valid/ready request channel to the APB master
// and stretches the AHB data phase until the APB response returns.
// Request channel: req_valid_o rises in REQ and stays high, with req_* held
// stable, until req_ready_i is sampled high on a clock edge; the transfer is
// taken on that edge. rsp_valid_i is a one-cycle pulse, only honoured in WAIT.
// Macro AHB_ERR_RESP_EN enables two-cycle ERROR responses (PSLVERR, oversize).
module ahb_slave_frontend
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              preset_n,
    input  logic              hsel_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [DATA_W-1:0] hwdata_i,
    input  logic              hready_i,
    output logic              hreadyout_o,
    output logic [DATA_W-1:0] hrdata_o,
    output logic              hresp_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_write_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    input  logic              rsp_err_i
);

    fe_state_t         state_q, state_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_write;
    logic [2:0]        cap_size;
    logic              accept;
    logic              can_accept;
    logic              oversize;
    logic              rsp_is_err;
    logic              unused_sigs;

    // NONSEQ and SEQ both have htrans[1] set; IDLE/BUSY get a zero-wait OKAY.
    assign accept     = hsel_i & hready_i & htrans_i[1];
    assign can_accept = (state_q == FE_IDLE) || (state_q == FE_DONE) ||
                        (state_q == FE_ERR2);

`ifdef AHB_ERR_RESP_EN
    assign oversize    = (hsize_i > HSIZE_WORD);
    assign rsp_is_err  = rsp_err_i;
    assign unused_sigs = ^{htrans_i[0], cap_size};
`else
    // Oversize transfers proceed as word accesses; PSLVERR is dropped.
    assign oversize    = 1'b0;
    assign rsp_is_err  = 1'b0;
    assign unused_sigs = ^{htrans_i[0], cap_size, rsp_err_i};
`endif

    ahb_addr_capture #(
        .ADDR_W (ADDR_W)
    ) u_addr_capture (
        .clk      (clk),
        .preset_n (preset_n),
        .load_i   (accept & can_accept),
        .addr_i   (haddr_i),
        .write_i  (hwrite_i),
        .size_i   (hsize_i),
        .addr_o   (cap_addr),
        .write_o  (cap_write),
        .size_o   (cap_size)
    );

    // Next-state and datapath update for the front-end FSM.
    always_comb begin
        state_d  = state_q;
        hrdata_d = hrdata_q;
        wdata_d  = wdata_q;
        case (state_q)
            FE_IDLE, FE_DONE, FE_ERR2: begin
                if (accept) begin
                    if (oversize)      state_d = FE_ERR1;
                    else if (hwrite_i) state_d = FE_WDATA;
                    else               state_d = FE_REQ;
                end else begin
                    state_d = FE_IDLE;
                end
            end
            FE_WDATA: begin
                wdata_d = hwdata_i;
                state_d = FE_REQ;
            end
            FE_REQ: begin
                if (req_ready_i) state_d = FE_WAIT;
            end
            FE_WAIT: begin
                if (rsp_valid_i) begin
                    if (rsp_is_err) begin
                        state_d = FE_ERR1;
                    end else begin
                        state_d = FE_DONE;
                        if (!cap_write) hrdata_d = rsp_rdata_i;
                    end
                end
            end
            FE_ERR1: state_d = FE_ERR2;
            default: state_d = FE_IDLE;
        endcase
    end

    // State and data registers; reset drops any in-flight transfer silently.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q  <= FE_IDLE;
            hrdata_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            hrdata_q <= hrdata_d;
            wdata_q  <= wdata_d;
        end
    end

    assign hreadyout_o = !((state_q == FE_WDATA) || (state_q == FE_REQ) ||
                           (state_q == FE_WAIT)  || (state_q == FE_ERR1));
`ifdef AHB_ERR_RESP_EN
    assign hresp_o = ((state_q == FE_ERR1) || (state_q == FE_ERR2)) ? HRESP_ERROR
                                                                     : HRESP_OKAY;
`else
    assign hresp_o = HRESP_OKAY;
`endif
    assign hrdata_o    = hrdata_q;
    assign req_valid_o = (state_q == FE_REQ);
    assign req_addr_o  = cap_addr;
    assign req_write_o = cap_write;
    assign req_wdata_o = wdata_q;

endmodule

// File: tb/tb_ahb_slave_frontend.sv
// Directed bench for ahb_slave_frontend. Inputs change 1ns after the rising
// edge; outputs are checked at that point. A negedge monitor scores every
// request handshake against the queue of expected addresses.
// Build with +define+AHB_ERR_RESP_EN to exercise the error-response variant.
`timescale 1ns/1ps
module tb_ahb_slave_frontend;
    import bridge_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              preset_n;
    logic              hsel_i;
    logic [ADDR_W-1:0] haddr_i;
    logic [1:0]        htrans_i;
    logic              hwrite_i;
    logic [2:0]        hsize_i;
    logic [DATA_W-1:0] hwdata_i;
    logic              hready_i;
    logic              hreadyout_o;
    logic [DATA_W-1:0] hrdata_o;
    logic              hresp_o;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_write_o;
    logic [DATA_W-1:0] req_wdata_o;
    logic              rsp_valid_i;
    logic [DATA_W-1:0] rsp_rdata_i;
    logic              rsp_err_i;

    ahb_slave_frontend #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .preset_n(preset_n),
        .hsel_i(hsel_i), .haddr_i(haddr_i), .htrans_i(htrans_i),
        .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
        .hready_i(hready_i), .hreadyout_o(hreadyout_o), .hrdata_o(hrdata_o),
        .hresp_o(hresp_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_write_o(req_write_o),
        .req_wdata_o(req_wdata_o), .rsp_valid_i(rsp_valid_i),
        .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input fe_state_t exp);
        check_val(tag, 64'(dut.state_q), 64'(exp));
    endtask

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        hsel_i   = 1'b0;
        htrans_i = HTRANS_IDLE;
        hready_i = 1'b1;
    endtask

    task automatic ahb_addr(input logic [ADDR_W-1:0] a, input logic w,
                            input htrans_t tr, input logic [2:0] sz);
        hsel_i   = 1'b1;
        haddr_i  = a;
        hwrite_i = w;
        htrans_i = tr;
        hsize_i  = sz;
        hready_i = 1'b1;
    endtask

    task automatic rsp_pulse(input logic [DATA_W-1:0] d, input logic err);
        rsp_valid_i = 1'b1;
        rsp_rdata_i = d;
        rsp_err_i   = err;
    endtask

    task automatic rsp_clear;
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
    endtask

    // Scoreboard: each request handshake must match the next expected address
    always @(negedge clk) begin
        if (preset_n && req_valid_o && req_ready_i) begin
            hs_count++;
            check_val("req_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_val("req_addr_order", req_addr_o, exp_q.pop_front());
        end
    end

    initial begin
        preset_n = 1'b0;
        haddr_i = '0; hwrite_i = 1'b0; hsize_i = HSIZE_WORD; hwdata_i = '0;
        req_ready_i = 1'b0; rsp_rdata_i = '0;
        bus_idle();
        rsp_clear();
        repeat (3) tick();

        // Reset values
        check_val("rst_hreadyout", hreadyout_o, 1);
        check_val("rst_hresp", hresp_o, 0);
        check_val("rst_hrdata", hrdata_o, 0);
        check_val("rst_req_valid", req_valid_o, 0);
        check_val("rst_req_addr", req_addr_o, 0);
        check_val("rst_req_write", req_write_o, 0);
        check_val("rst_req_wdata", req_wdata_o, 0);
        check_state("rst_state", FE_IDLE);
        preset_n = 1'b1;
        tick();

        // 1: read A000, ready at T1, response at T2
        ahb_addr(32'hA000, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
        exp_q.push_back(32'hA000);
        tick();
        check_val("t1_req_valid", req_valid_o, 1);
        check_val("t1_hreadyout_T1", hreadyout_o, 0);
        check_val("t1_req_addr", req_addr_o, 32'hA000);
        check_val("t1_req_write", req_write_o, 0);
        bus_idle();
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        check_val("t1_hreadyout_T2", hreadyout_o, 0);
        check_val("t1_req_valid_drop", req_valid_o, 0);
        rsp_pulse(32'hDEADBEEF, 1'b0);
        tick();
        rsp_clear();
        check_val("t1_hreadyout_T3", hreadyout_o, 1);
        check_val("t1_hrdata", hrdata_o, 32'hDEADBEEF);
        check_val("t1_hresp", hresp_o, 0);
        check_state("t1_state_done", FE_DONE);
        tick();
        check_state("t1_state_idle", FE_IDLE);

        // 2: write A004, ready held low for 3 cycles
        ahb_addr(32'hA004, 1'b1, HTRANS_NONSEQ, HSIZE_WORD);
        exp_q.push_back(32'hA004);
        tick();
        check_state("t2_state_wdata", FE_WDATA);
        check_val("t2_wdata_hreadyout", hreadyout_o, 0);
        check_val("t2_wdata_req_valid", req_valid_o, 0);
        bus_idle();
        hwdata_i = 32'h12345678;
        tick();
        hwdata_i = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            check_val("t2_hold_valid", req_valid_o, 1);
            check_val("t2_hold_addr", req_addr_o, 32'hA004);
            check_val("t2_hold_write", req_write_o, 1);
            check_val("t2_hold_wdata", req_wdata_o, 32'h12345678);
            check_val("t2_hold_hreadyout", hreadyout_o, 0);
            tick();
        end
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        check_val("t2_wait_req_valid", req_valid_o, 0);
        rsp_pulse(32'hFFFF0000, 1'b0);
        tick();
        rsp_clear();
        check_val("t2_done_hreadyout", hreadyout_o, 1);
        check_val("t2_hrdata_kept", hrdata_o, 32'hDEADBEEF);
        tick();

        // 3: NONSEQ read A000 then SEQ read A004 pipelined in DONE
        ahb_addr(32'hA000, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
        exp_q.push_back(32'hA000);
        tick();
        bus_idle();
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        rsp_pulse(32'h11111111, 1'b0);
        tick();
        rsp_clear();
        check_val("t3_first_hrdata", hrdata_o, 32'h11111111);
        check_state("t3_first_done", FE_DONE);
        ahb_addr(32'hA004, 1'b0, HTRANS_SEQ, HSIZE_WORD);
        exp_q.push_back(32'hA004);
        tick();
        bus_idle();
        check_state("t3_second_req", FE_REQ);
        check_val("t3_second_addr", req_addr_o, 32'hA004);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        rsp_pulse(32'h22222222, 1'b0);
        tick();
        rsp_clear();
        check_val("t3_second_hrdata", hrdata_o, 32'h22222222);
        tick();

        // 4: BUSY / IDLE transfers and hready_i=0 are ignored
        ahb_addr(32'hB000, 1'b0, HTRANS_BUSY, HSIZE_WORD);
        tick();
        check_val("t4_busy_req_valid", req_valid_o, 0);
        check_val("t4_busy_hreadyout", hreadyout_o, 1);
        check_state("t4_busy_state", FE_IDLE);
        ahb_addr(32'hB000, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
        hready_i = 1'b0;
        tick();
        check_val("t4_nrdy_req_valid", req_valid_o, 0);
        check_val("t4_nrdy_hreadyout", hreadyout_o, 1);
        ahb_addr(32'hB000, 1'b1, HTRANS_IDLE, HSIZE_WORD);
        tick();
        check_state("t4_idle_state", FE_IDLE);
        bus_idle();

        // 5: reset asserted in WAIT drops the transfer; late response ignored
        ahb_addr(32'hA008, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
        exp_q.push_back(32'hA008);
        tick();
        bus_idle();
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        check_state("t5_wait", FE_WAIT);
        preset_n = 1'b0;
        #1;
        check_val("t5_rst_req_valid", req_valid_o, 0);
        check_val("t5_rst_hreadyout", hreadyout_o, 1);
        check_state("t5_rst_state", FE_IDLE);
        rsp_pulse(32'h55555555, 1'b0);
        tick();
        preset_n = 1'b1;
        tick();
        rsp_clear();
        check_state("t5_late_rsp_state", FE_IDLE);
        check_val("t5_late_rsp_hrdata", hrdata_o, 0);
        check_val("t5_late_hreadyout", hreadyout_o, 1);

        // 6: APB error response, then oversize transfer
        ahb_addr(32'hA00C, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
        exp_q.push_back(32'hA00C);
        tick();
        bus_idle();
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        rsp_pulse(32'h33333333, 1'b1);
        tick();
        rsp_clear();
`ifdef AHB_ERR_RESP_EN
        check_val("t6_err1_hresp", hresp_o, 1);
        check_val("t6_err1_hreadyout", hreadyout_o, 0);
        check_state("t6_err1_state", FE_ERR1);
        tick();
        check_val("t6_err2_hresp", hresp_o, 1);
        check_val("t6_err2_hreadyout", hreadyout_o, 1);
        check_val("t6_err_hrdata", hrdata_o, 0);
        // Oversize accepted in ERR2 goes straight to ERR1 with no request
        ahb_addr(32'hA010, 1'b0, HTRANS_NONSEQ, 3'b011);
        tick();
        bus_idle();
        check_state("t6_ovs_err1", FE_ERR1);
        check_val("t6_ovs_req_valid", req_valid_o, 0);
        check_val("t6_ovs_hresp", hresp_o, 1);
        tick();
        check_val("t6_ovs_err2_hreadyout", hreadyout_o, 1);
        tick();
        check_val("t6_after_hresp", hresp_o, 0);
        check_state("t6_after_state", FE_IDLE);
`else
        check_val("t6_okay_hresp", hresp_o, 0);
        check_val("t6_okay_hreadyout", hreadyout_o, 1);
        check_val("t6_okay_hrdata", hrdata_o, 32'h33333333);
        // Oversize treated as a word access: request issued normally
        ahb_addr(32'hA010, 1'b0, HTRANS_NONSEQ, 3'b011);
        exp_q.push_back(32'hA010);
        tick();
        bus_idle();
        check_val("t6_ovs_req_valid", req_valid_o, 1);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        rsp_pulse(32'h44444444, 1'b1);
        tick();
        rsp_clear();
        check_val("t6_ovs_hrdata", hrdata_o, 32'h44444444);
        check_val("t6_ovs_hresp", hresp_o, 0);
        tick();
`endif

        // Every expected request seen exactly once
        check_val("sb_queue_empty", 64'(exp_q.size()), 0);
`ifdef AHB_ERR_RESP_EN
        check_val("sb_req_count", 64'(hs_count), 6);
`else
        check_val("sb_req_count", 64'(hs_count), 7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
